neuron_spike_out_csr: RTL and testbench
=======================================

// Module: neuron_spike_out_csr
// PURPOSE
//  Wishbone-B4 classic slave holding one 32-bit neuron spike-output word.
//  The neuron core writes the word through a dedicated side port each
//  timestep. The management SoC reads it, or overwrites it, over Wishbone.
//  Sits on the user-project Wishbone bus at 0x3000_8000.
// PARAMETERS
//  BASE_ADDR   32'h3000_8000  word address decoded (adr[31:2] compared)
//  DATA_W      32             register / bus data width (fixed at 32)
// PORTS
//  wb_clk_i               in   1   single clock; all logic on rising edge
//  wb_rst_i               in   1   reset, synchronous, active-low
//  wbs_cyc_i              in   1   bus cycle valid
//  wbs_stb_i              in   1   strobe
//  wbs_we_i               in   1   1=write, 0=read
//  wbs_sel_i              in   4   byte enables for writes
//  wbs_adr_i              in   32  byte address
//  wbs_dat_i              in   32  write data
//  wbs_ack_o              out  1   transfer acknowledge
//  wbs_dat_o              out  32  read data
//  external_spike_data_i  in   32  spike word from neuron core
//  external_write_en_i    in   1   load external_spike_data_i this cycle
//  irq_o                  out  1   only when SPIKE_OUT_IRQ_EN is defined
// BEHAVIOUR
//  - Reset (wb_rst_i=0 at a clock edge): spike_q=0, wbs_ack_o=0,
//    wbs_dat_o=0, irq_o=0. Reset has priority over every other event.
//  - hit = cyc & stb & (adr[31:2]==BASE_ADDR[31:2]) & ~wbs_ack_o.
//  - Handshake: on a hit, wbs_ack_o=1 on the next edge, for exactly one
//    cycle. A new ack needs a fresh hit, so a held stb gives one ack per
//    two cycles. Misses are never acked and change no state.
//  - Write hit: byte lane i of spike_q <= wbs_dat_i[8i+7:8i] when sel[i]=1.
//    The register updates on the same edge that raises ack.
//  - Read hit: wbs_dat_o <= spike_q (value before this edge), registered
//    with ack. wbs_dat_o returns to 0 on the cycle after ack.
//  - External: external_write_en_i=1 at an edge -> spike_q <=
//    external_spike_data_i (full word; sel ignored). Level-sensitive:
//    every enabled cycle reloads the register.
//  - Simultaneous external write and WB write hit: the external write wins
//    for all bytes. The WB write is still acked.
//  - Simultaneous external write and WB read hit: the read returns the old
//    spike_q. The new value is visible from the next read.
//  - Adr[1:0] is ignored. There are no error/retry signals. Latency is
//    fixed at 1 cycle.
// CONFIGURATION
//  SPIKE_OUT_IRQ_EN defined: irq_o is a sticky flag. It is set on any
//    external write and cleared by a WB read hit (on the ack edge).
//    Set wins over clear in the same cycle.
//  SPIKE_OUT_IRQ_EN undefined: no irq_o port and no flag logic.
//    Register behaviour is otherwise identical.
// STRUCTURE
//  Shared package neuron_pkg: SPIKE_OUT_BASE_ADDR (32'h3000_8000) and
//    SPIKE_W (32), reused by the neuron core and the bus address map.
//  Single flat module with no sub-modules. Contents: address decode,
//    ack flop, byte-lane write mux with external priority, and read flop.
// TESTING
//  1 Reset: hold wb_rst_i=0 for 4 clks, then release. Read 0x3000_8000
//    -> dat_o=0x0000_0000, ack 1 cycle after stb.
//  2 WB write 0x1234_5678 (sel=F), then read -> 0x1234_5678. Each ack lasts
//    exactly 1 cycle.
//  3 external_write_en_i=1 with data 0xDEAD_BEEF for 1 clk, then WB read
//    -> 0xDEAD_BEEF (overrides the prior WB value).
//  4 Starting from reg=0xFFFF_FFFF: write 0x0000_00AA with sel=4'b0001
//    -> read 0xFFFF_FFAA.
//  5 Same edge: WB write 0x1111_1111 and external 0x2222_2222 -> read
//    0x2222_2222. Read to 0x3000_8004 -> no ack within 8 clks.
//  6 With SPIKE_OUT_IRQ_EN: external write -> irq_o=1 next cycle. WB read
//    -> irq_o=0 after the ack edge.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared neuron constants: spike-output CSR location on the user-project bus
// and the spike word width used by the neuron core and the bus address map.
package neuron_pkg;

    localparam logic [31:0] SPIKE_OUT_BASE_ADDR = 32'h3000_8000;
    localparam int          SPIKE_W             = 32;
    localparam int          SPIKE_BYTES         = SPIKE_W / 8;

endpackage

// File: rtl/neuron_spike_out_csr.sv
// Wishbone-B4 classic slave holding the neuron spike-output word, with a
// core-side load port. Define SPIKE_OUT_IRQ_EN to add the sticky irq_o flag.
module neuron_spike_out_csr
    import neuron_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = SPIKE_OUT_BASE_ADDR,
    parameter int          DATA_W    = SPIKE_W
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [DATA_W/8-1:0] wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [DATA_W-1:0]   wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [DATA_W-1:0]   wbs_dat_o,
    input  logic [DATA_W-1:0]   external_spike_data_i,
    input  logic                external_write_en_i
`ifdef SPIKE_OUT_IRQ_EN
    ,
    output logic                irq_o
`endif
);

    logic                ack_reg;
    logic [DATA_W-1:0]   spike_reg;
    logic [DATA_W-1:0]   spike_next;
    logic [DATA_W-1:0]   dat_o_reg;
    logic [DATA_W-1:0]   dat_o_next;
    logic                hit;
    logic                wr_hit;
    logic                rd_hit;
    logic                unused_adr_bits;

    // Byte offset within the word plays no part in decode.
    assign unused_adr_bits = ^wbs_adr_i[1:0];

    // The pending ack term blocks a second hit, so a held strobe is acked
    // every other cycle.
    assign hit    = wbs_cyc_i & wbs_stb_i
                  & (wbs_adr_i[31:2] == BASE_ADDR[31:2]) & ~ack_reg;
    assign wr_hit = hit & wbs_we_i;
    assign rd_hit = hit & ~wbs_we_i;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
            always_comb begin
                spike_next[gi*8 +: 8] = spike_reg[gi*8 +: 8];
                if (external_write_en_i) begin
                    spike_next[gi*8 +: 8] = external_spike_data_i[gi*8 +: 8];
                end else if (wr_hit && wbs_sel_i[gi]) begin
                    spike_next[gi*8 +: 8] = wbs_dat_i[gi*8 +: 8];
                end
            end
        end
    endgenerate

    // Read data is only non-zero during the ack cycle.
    assign dat_o_next = rd_hit ? spike_reg : '0;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            ack_reg   <= 1'b0;
            spike_reg <= '0;
            dat_o_reg <= '0;
        end else begin
            ack_reg   <= hit;
            spike_reg <= spike_next;
            dat_o_reg <= dat_o_next;
        end
    end

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_o_reg;

`ifdef SPIKE_OUT_IRQ_EN
    logic irq_reg;
    logic irq_next;

    // A core load in the same cycle as a clearing read keeps the flag set.
    always_comb begin
        irq_next = irq_reg;
        if (rd_hit) begin
            irq_next = 1'b0;
        end
        if (external_write_en_i) begin
            irq_next = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= irq_next;
        end
    end

    assign irq_o = irq_reg;
`endif

endmodule

// File: tb/tb_neuron_spike_out_csr.sv
// Self-checking bench for neuron_spike_out_csr: directed steps then random
// traffic against a word-level model. Honours SPIKE_OUT_IRQ_EN like the DUT.
module tb_neuron_spike_out_csr;

    localparam logic [31:0] BASE = 32'h3000_8000;

    logic        tb_clk;
    logic        wb_rst_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] external_spike_data_i;
    logic        external_write_en_i;
`ifdef SPIKE_OUT_IRQ_EN
    logic        irq_o;
`endif

    neuron_spike_out_csr dut (
        .wb_clk_i              (tb_clk),
        .wb_rst_i              (wb_rst_i),
        .wbs_cyc_i             (wbs_cyc_i),
        .wbs_stb_i             (wbs_stb_i),
        .wbs_we_i              (wbs_we_i),
        .wbs_sel_i             (wbs_sel_i),
        .wbs_adr_i             (wbs_adr_i),
        .wbs_dat_i             (wbs_dat_i),
        .wbs_ack_o             (wbs_ack_o),
        .wbs_dat_o             (wbs_dat_o),
        .external_spike_data_i (external_spike_data_i),
        .external_write_en_i   (external_write_en_i)
`ifdef SPIKE_OUT_IRQ_EN
        ,
        .irq_o                 (irq_o)
`endif
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_txn = 0;
    logic [31:0] spike_m;   // model of the stored word
    bit          irq_m;     // model of the sticky flag

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_irq(input string tag);
`ifdef SPIKE_OUT_IRQ_EN
        chk(tag, {31'd0, irq_o}, {31'd0, irq_m});
`else
        n_txn = n_txn + 0;
`endif
    endtask

    task automatic idle_bus();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0;
        wbs_dat_i = 32'h0;
        external_write_en_i   = 1'b0;
        external_spike_data_i = 32'h0;
    endtask

    // One single-beat transfer started at a negedge, optionally with a core
    // load on the same edge. Checks the ack cycle and the cycle after.
    task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit ext, input logic [31:0] ext_d);
        bit          is_hit;
        logic [31:0] mask;
        logic [31:0] exp_rd;
        is_hit = (adr[31:2] == BASE[31:2]);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        external_write_en_i   = ext;
        external_spike_data_i = ext_d;
        @(negedge tb_clk);
        exp_rd = (is_hit && !we) ? spike_m : 32'h0;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        if (ext)
            spike_m = ext_d;
        else if (is_hit && we)
            spike_m = (spike_m & ~mask) | (dat & mask);
        if (is_hit && !we)
            irq_m = 1'b0;
        if (ext)
            irq_m = 1'b1;
        n_txn++;
        $display("txn %0d: %s adr=%h dat=%h sel=%h ext=%0d ext_d=%h -> ack=%0d dat_o=%h",
                 n_txn, we ? "WR" : "RD", adr, dat, sel, ext, ext_d, wbs_ack_o, wbs_dat_o);
        chk("ack", {31'd0, wbs_ack_o}, {31'd0, is_hit});
        chk("dat_o", wbs_dat_o, exp_rd);
        chk_irq("irq");
        idle_bus();
        @(negedge tb_clk);
        chk("ack_drop", {31'd0, wbs_ack_o}, 32'd0);
        chk("dat_o_drop", wbs_dat_o, 32'h0);
    endtask

    task automatic ext_pulse(input logic [31:0] d);
        external_write_en_i   = 1'b1;
        external_spike_data_i = d;
        @(negedge tb_clk);
        spike_m = d;
        irq_m   = 1'b1;
        n_txn++;
        $display("txn %0d: EXT dat=%h", n_txn, d);
        chk_irq("irq_set");
        chk("ext_no_ack", {31'd0, wbs_ack_o}, 32'd0);
        idle_bus();
    endtask

    initial begin
        logic [31:0] r_adr;
        logic [31:0] r_dat;
        int          op;

        idle_bus();
        spike_m  = 32'h0;
        irq_m    = 1'b0;
        wb_rst_i = 1'b0;
        repeat (4) @(negedge tb_clk);
        chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk_irq("rst_irq");
        wb_rst_i = 1'b1;

        // Reset value, then plain write/read.
        xfer(1'b0, BASE, 32'h0, 4'h0, 1'b0, 32'h0);
        xfer(1'b1, BASE, 32'h1234_5678, 4'hF, 1'b0, 32'h0);
        xfer(1'b0, BASE, 32'h0, 4'h0, 1'b0, 32'h0);

        // Core load overrides the bus value; read clears the flag.
        ext_pulse(32'hDEAD_BEEF);
        xfer(1'b0, BASE, 32'h0, 4'h0, 1'b0, 32'h0);
        chk_irq("irq_cleared");

        // Single byte-lane write.
        xfer(1'b1, BASE, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
        xfer(1'b1, BASE, 32'h0000_00AA, 4'b0001, 1'b0, 32'h0);
        xfer(1'b0, BASE, 32'h0, 4'h0, 1'b0, 32'h0);
        chk("lane0", spike_m, 32'hFFFF_FFAA);

        // Core load beats a concurrent bus write; concurrent read sees old word.
        xfer(1'b1, BASE, 32'h1111_1111, 4'hF, 1'b1, 32'h2222_2222);
        xfer(1'b0, BASE, 32'h0, 4'h0, 1'b1, 32'h3333_3333);
        xfer(1'b0, BASE + 32'h3, 32'h0, 4'h0, 1'b0, 32'h0);

        // Neighbouring word is never acked.
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_adr_i = BASE + 32'h4;
        for (int i = 0; i < 8; i++) begin
            @(negedge tb_clk);
            chk("miss_no_ack", {31'd0, wbs_ack_o}, 32'd0);
        end
        idle_bus();

        // Held strobe: one ack every two cycles.
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_adr_i = BASE;
        for (int i = 0; i < 4; i++) begin
            @(negedge tb_clk);
            if (i == 0) irq_m = 1'b0;
            chk("held_ack", {31'd0, wbs_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("held_dat", wbs_dat_o, (i % 2 == 0) ? spike_m : 32'h0);
        end
        idle_bus();
        @(negedge tb_clk);
        chk_irq("held_irq");

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            op    = $urandom_range(0, 4);
            r_dat = $urandom;
            r_adr = BASE | {30'd0, 2'($urandom_range(0, 3))};
            case (op)
                0: xfer(1'b1, r_adr, r_dat, 4'($urandom), 1'b0, 32'h0);
                1: xfer(1'b0, r_adr, 32'h0, 4'h0, 1'b0, 32'h0);
                2: ext_pulse(r_dat);
                3: xfer(1'($urandom), r_adr, r_dat, 4'($urandom), 1'b1, $urandom);
                default: begin
                    r_adr = $urandom;
                    if (r_adr[31:2] == BASE[31:2]) r_adr = r_adr ^ 32'h0000_0100;
                    xfer(1'($urandom), r_adr, r_dat, 4'hF, 1'b0, 32'h0);
                end
            endcase
        end
        xfer(1'b0, BASE, 32'h0, 4'h0, 1'b0, 32'h0);

        // Reset beats a concurrent bus write and core load.
        external_write_en_i   = 1'b1;
        external_spike_data_i = 32'hCAFE_F00D;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_sel_i = 4'hF;
        wbs_adr_i = BASE;
        wbs_dat_i = 32'h5555_5555;
        wb_rst_i  = 1'b0;
        @(negedge tb_clk);
        spike_m = 32'h0;
        irq_m   = 1'b0;
        chk("rst_pri_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk_irq("rst_pri_irq");
        idle_bus();
        wb_rst_i = 1'b1;
        xfer(1'b0, BASE, 32'h0, 4'h0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
